gcd_arbiter: RTL and testbench
==============================

Name: gcd_arbiter

Overview:
Shares one iterative GCD unit (control + datapath, val/rdy operand and result interfaces) among NREQ requesters. Round-robin arbitration, one transaction in flight at a time. Latches the winner's operands, issues them to the GCD unit, captures the result and returns it to the originating requester. Sits between client blocks and the single gcd instance, on the same clk/rst_b domain.

Parameters:
WL, 8, operand/result width in bits (matches GCD unit WL)
NREQ, 4, number of requesters; 2..16
IDW, $clog2(NREQ), derived width of requester index (localparam)

Ports:
clk  input  1  clock, rising edge
rst_b  input  1  asynchronous active-low reset
req_ops_val  input  NREQ  per-requester operand valid
req_ops_rdy  output  NREQ  per-requester operand ready (one-hot or zero)
req_A  input  NREQ x WL  per-requester operand A (packed [NREQ-1:0][WL-1:0])
req_B  input  NREQ x WL  per-requester operand B
req_res_val  output  NREQ  per-requester result valid (one-hot or zero)
req_res_rdy  input  NREQ  per-requester result ready
req_res  output  WL  result bus shared by all requesters
gcd_ops_val  output  1  operand valid to GCD unit
gcd_ops_rdy  input  1  operand ready from GCD unit
gcd_A  output  WL  operand A to GCD unit
gcd_B  output  WL  operand B to GCD unit
gcd_res_val  input  1  result valid from GCD unit
gcd_res_rdy  output  1  result ready to GCD unit
gcd_res  input  WL  result from GCD unit
busy  output  1  transaction in flight (state != IDLE)
grant_id  output  IDW  index of current/last granted requester

Behaviour:
- Clock clk; reset rst_b asynchronous, active-low. Reset: state=IDLE, rr_ptr=0, grant_id=0, latched A/B/result=0; all val/rdy outputs 0, busy=0, req_res=0, gcd_A/gcd_B=0.
- FSM states: IDLE, ISSUE, WAIT, RETURN.
- IDLE: winner = first i with req_ops_val[i]=1, searching i = rr_ptr, rr_ptr+1, ... mod NREQ. req_ops_rdy[winner]=1 combinationally, all other bits 0. On handshake: latch req_A/req_B[winner] and grant_id=winner; -> ISSUE. No val: stay, req_ops_rdy=0.
- ISSUE: gcd_ops_val=1, gcd_A/gcd_B = latched operands (stable until accepted). gcd_ops_rdy=1 -> WAIT. Operands reach GCD unit 1 cycle after requester handshake.
- WAIT: gcd_res_rdy=1. gcd_res_val=1 -> latch gcd_res; -> RETURN.
- RETURN: req_res_val[grant_id]=1, req_res=latched result (stable until accepted). req_res_rdy[grant_id]=1 -> rr_ptr = grant_id+1, wrapping NREQ-1 -> 0; -> IDLE. req_res_rdy of other requesters ignored.
- Fairness: a requester that just completed has lowest priority next arbitration; with all NREQ requesting continuously, grants rotate 0,1,2,...,NREQ-1,0.
- No operand accepted outside IDLE: req_ops_rdy=0 in ISSUE/WAIT/RETURN. Back-to-back: earliest next accept is the cycle after RETURN handshake.
- Requester protocol: val held until rdy; operands stable while val. Arbiter does not check.
- Operand values passed unmodified (including 0); zero-operand semantics belong to the GCD unit.
- Reset mid-transaction: in-flight transaction dropped, no result returned; GCD unit shares rst_b.
- busy=1 in ISSUE, WAIT, RETURN.

Decomposition:
- gcd_pkg: arb_state_t enum {IDLE, ISSUE, WAIT, RETURN}; shared WL default constant.
- Sub-module rr_picker (combinational): inputs req[NREQ], ptr[IDW]; outputs any, idx[IDW]. Rotate-and-priority-encode. Unit-testable alone.
- gcd_arbiter: FSM, operand/result registers, rr_ptr, output muxing.

Test Plan:
- Single request: req 0 sends A=6,B=4 with GCD unit attached -> req_res_val[0] asserted with req_res=2; gcd_ops_val 1 cycle after req_ops_rdy[0]; busy high ISSUE..RETURN.
- Simultaneous: reqs 0..3 with (6,8),(12,18),(7,5),(9,3) held at reset release -> grants 0,1,2,3 in order; results 2,6,1,3 each on matching req_res_val bit only.
- Rotation/wrap: rr_ptr=3 after serving req 2; reqs 0 and 3 request -> 3 served first, then 0 (pointer wraps 3->0).
- Backpressure: gcd_ops_rdy low 5 cycles in ISSUE, then req_res_rdy[1] low 4 cycles in RETURN -> gcd_A/gcd_B and req_res stable throughout; no req_ops_rdy bit asserts.
- Reset mid-op: rst_b low during WAIT for req 2 (A=6,B=4) -> outputs go to reset values immediately (asynchronous); after release rr_ptr=0, no result delivered, new request from req 1 (10,4) returns 2.
- Idle: no req_ops_val for 20 cycles -> all rdy/val outputs 0, busy=0, state IDLE.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD request arbiter.
package gcd_pkg;

  localparam int GCD_WL = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    RETURN = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: returns the first asserted request at or after ptr, wrapping modulo NREQ.
module rr_picker #(
  parameter int  NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            any,
  output logic [IDW-1:0]  idx
);

  // Scan offsets from farthest to nearest so the candidate closest to ptr wins.
  always_comb begin
    int   sum_s;
    int   cand_s;
    logic hit_s;
    any    = 1'b0;
    idx    = {IDW{1'b0}};
    sum_s  = 0;
    cand_s = 0;
    hit_s  = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum_s  = int'(ptr) + k;
      cand_s = (sum_s >= NREQ) ? (sum_s - NREQ) : sum_s;
      hit_s  = req[cand_s[IDW-1:0]];
      any    = any | hit_s;
      idx    = hit_s ? cand_s[IDW-1:0] : idx;
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// Shares one iterative GCD unit among NREQ requesters, one transaction in flight,
// round-robin arbitration with the last-served requester at lowest priority.
module gcd_arbiter
  import gcd_pkg::*;
#(
  parameter int  WL   = GCD_WL,
  parameter int  NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic [NREQ-1:0]          req_ops_val,
  output logic [NREQ-1:0]          req_ops_rdy,
  input  logic [NREQ-1:0][WL-1:0]  req_A,
  input  logic [NREQ-1:0][WL-1:0]  req_B,
  output logic [NREQ-1:0]          req_res_val,
  input  logic [NREQ-1:0]          req_res_rdy,
  output logic [WL-1:0]            req_res,
  output logic                     gcd_ops_val,
  input  logic                     gcd_ops_rdy,
  output logic [WL-1:0]            gcd_A,
  output logic [WL-1:0]            gcd_B,
  input  logic                     gcd_res_val,
  output logic                     gcd_res_rdy,
  input  logic [WL-1:0]            gcd_res,
  output logic                     busy,
  output logic [IDW-1:0]           grant_id
);

  arb_state_t     state_r;
  arb_state_t     state_nxt_s;
  logic [IDW-1:0] rr_ptr_r;
  logic [IDW-1:0] grant_id_r;
  logic [WL-1:0]  a_r;
  logic [WL-1:0]  b_r;
  logic [WL-1:0]  res_r;
  logic           pick_any_s;
  logic [IDW-1:0] pick_idx_s;
  logic           ops_hs_s;
  logic           res_cap_s;
  logic           ret_hs_s;

  rr_picker #(
    .NREQ (NREQ)
  ) u_picker (
    .req (req_ops_val),
    .ptr (rr_ptr_r),
    .any (pick_any_s),
    .idx (pick_idx_s)
  );

  // Next-state and handshake decode. The ready is also masked by rst_b so no
  // requester can see a handshake that the held-in-reset registers would drop.
  always_comb begin
    state_nxt_s = state_r;
    req_ops_rdy = {NREQ{1'b0}};
    req_res_val = {NREQ{1'b0}};
    gcd_ops_val = 1'b0;
    gcd_res_rdy = 1'b0;
    ops_hs_s    = 1'b0;
    res_cap_s   = 1'b0;
    ret_hs_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_any_s && rst_b) begin
          req_ops_rdy[pick_idx_s] = 1'b1;
          ops_hs_s                = 1'b1;
          state_nxt_s             = ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        gcd_ops_val = 1'b1;
        if (gcd_ops_rdy) begin
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = ISSUE;
        end
      end
      WAIT: begin
        gcd_res_rdy = 1'b1;
        if (gcd_res_val) begin
          res_cap_s   = 1'b1;
          state_nxt_s = RETURN;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      RETURN: begin
        req_res_val[grant_id_r] = 1'b1;
        if (req_res_rdy[grant_id_r]) begin
          ret_hs_s    = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RETURN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, operand/result latches and the round-robin pointer.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_r    <= IDLE;
      rr_ptr_r   <= {IDW{1'b0}};
      grant_id_r <= {IDW{1'b0}};
      a_r        <= {WL{1'b0}};
      b_r        <= {WL{1'b0}};
      res_r      <= {WL{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (ops_hs_s) begin
        a_r        <= req_A[pick_idx_s];
        b_r        <= req_B[pick_idx_s];
        grant_id_r <= pick_idx_s;
      end
      if (res_cap_s) begin
        res_r <= gcd_res;
      end
      if (ret_hs_s) begin
        rr_ptr_r <= (grant_id_r == IDW'(NREQ - 1)) ? {IDW{1'b0}} : (grant_id_r + IDW'(1));
      end
    end
  end

  assign gcd_A    = a_r;
  assign gcd_B    = b_r;
  assign req_res  = res_r;
  assign grant_id = grant_id_r;
  assign busy     = (state_r != IDLE);

endmodule

// File: tb/tb_gcd_arbiter.sv
// Self-checking bench for gcd_arbiter: behavioural requesters and GCD unit, plus a
// transaction-level reference model (round-robin pointer, in-flight transaction, expected GCD).
module tb_gcd_arbiter;

  localparam int WL   = 8;
  localparam int NREQ = 4;
  localparam int IDW  = $clog2(NREQ);

  logic                    clk = 1'b0;
  logic                    rst_b;
  logic [NREQ-1:0]         req_ops_val;
  logic [NREQ-1:0]         req_ops_rdy;
  logic [NREQ-1:0][WL-1:0] req_A;
  logic [NREQ-1:0][WL-1:0] req_B;
  logic [NREQ-1:0]         req_res_val;
  logic [NREQ-1:0]         req_res_rdy;
  logic [WL-1:0]           req_res;
  logic                    gcd_ops_val;
  logic                    gcd_ops_rdy;
  logic [WL-1:0]           gcd_A;
  logic [WL-1:0]           gcd_B;
  logic                    gcd_res_val;
  logic                    gcd_res_rdy;
  logic [WL-1:0]           gcd_res;
  logic                    busy;
  logic [IDW-1:0]          grant_id;

  gcd_arbiter #(.WL(WL), .NREQ(NREQ)) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .req_ops_val (req_ops_val),
    .req_ops_rdy (req_ops_rdy),
    .req_A       (req_A),
    .req_B       (req_B),
    .req_res_val (req_res_val),
    .req_res_rdy (req_res_rdy),
    .req_res     (req_res),
    .gcd_ops_val (gcd_ops_val),
    .gcd_ops_rdy (gcd_ops_rdy),
    .gcd_A       (gcd_A),
    .gcd_B       (gcd_B),
    .gcd_res_val (gcd_res_val),
    .gcd_res_rdy (gcd_res_rdy),
    .gcd_res     (gcd_res),
    .busy        (busy),
    .grant_id    (grant_id)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // requester side
  logic [NREQ-1:0] pend, waitres, res_rdy_en;
  logic [WL-1:0]   ra [NREQ];
  logic [WL-1:0]   rb [NREQ];
  // behavioural GCD unit
  logic            g_rdy_en;
  bit              g_busy, g_out;
  int              g_cnt, g_lat_max;
  logic [WL-1:0]   g_res_v;
  // reference model
  bit              m_inflight;
  int              m_id, m_ptr, m_last, m_age, n_acc;
  logic [WL-1:0]   m_a, m_b, m_exp;
  int              served_q[$];
  int              res_q[$];
  // handshakes observed at the sampling edge
  bit              hs_ops, hs_gacc, hs_gret, hs_res, seen_res;
  int              hs_id;
  logic [WL-1:0]   hs_ga, hs_gb, hs_rv;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int ref_gcd(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int exp_winner();
    for (int k = 0; k < NREQ; k++) begin
      if (pend[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic drive();
    req_ops_val = pend;
    for (int i = 0; i < NREQ; i++) begin
      req_A[i] = ra[i];
      req_B[i] = rb[i];
    end
    req_res_rdy = res_rdy_en;
    gcd_ops_rdy = g_rdy_en && !g_busy;
    gcd_res_val = g_out;
    gcd_res     = g_res_v;
  endtask

  task automatic check_cycle();
    logic [NREQ-1:0] exp_rdy;
    int w;
    exp_rdy = '0;
    w = exp_winner();
    if (!m_inflight && rst_b && w >= 0) exp_rdy[w] = 1'b1;
    check_eq("ops_rdy", req_ops_rdy, exp_rdy);
    check_eq("busy", busy, m_inflight);
    check_eq("grant_id", grant_id, m_last);
    if (m_inflight) begin
      if (m_age == 1) check_eq("issue_latency", gcd_ops_val, 1);
      if (gcd_ops_val) begin
        check_eq("gcd_A", gcd_A, m_a);
        check_eq("gcd_B", gcd_B, m_b);
      end
      if (req_res_val != '0) begin
        seen_res = 1'b1;
        check_eq("res_val_onehot", req_res_val, onehot(m_id));
        check_eq("req_res", req_res, m_exp);
      end
      if (m_age > 400) begin
        check_eq("txn_timeout_age", m_age, 400);
        m_inflight = 1'b0;
      end
    end else begin
      check_eq("gcd_ops_val_idle", gcd_ops_val, 0);
      check_eq("gcd_res_rdy_idle", gcd_res_rdy, 0);
      check_eq("res_val_idle", req_res_val, 0);
    end
    hs_ops = (req_ops_rdy & req_ops_val) != '0;
    hs_id  = 0;
    for (int i = NREQ - 1; i >= 0; i--) if (req_ops_rdy[i]) hs_id = i;
    hs_gacc = gcd_ops_val && gcd_ops_rdy;
    hs_ga   = gcd_A;
    hs_gb   = gcd_B;
    hs_gret = gcd_res_val && gcd_res_rdy;
    hs_res  = m_inflight && ((req_res_val & req_res_rdy) != '0);
    hs_rv   = req_res;
  endtask

  task automatic update();
    if (m_inflight) m_age++;
    if (hs_ops) begin
      pend[hs_id]    = 1'b0;
      waitres[hs_id] = 1'b1;
      m_inflight     = 1'b1;
      m_id           = hs_id;
      m_last         = hs_id;
      m_a            = ra[hs_id];
      m_b            = rb[hs_id];
      m_exp          = WL'(ref_gcd(int'(ra[hs_id]), int'(rb[hs_id])));
      m_age          = 1;
      n_acc++;
    end
    if (hs_res) begin
      served_q.push_back(m_id);
      res_q.push_back(int'(hs_rv));
      waitres[m_id] = 1'b0;
      m_inflight    = 1'b0;
      m_ptr         = (m_id + 1) % NREQ;
    end
    if (hs_gret) begin
      g_busy = 1'b0;
      g_out  = 1'b0;
    end else if (hs_gacc) begin
      g_busy  = 1'b1;
      g_cnt   = $urandom_range(g_lat_max, 1);
      g_res_v = WL'(ref_gcd(int'(hs_ga), int'(hs_gb)));
    end else if (g_busy && !g_out) begin
      g_cnt--;
      if (g_cnt <= 0) g_out = 1'b1;
    end
  endtask

  task automatic cycle();
    drive();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    update();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic wait_served(input int n, input int max_cyc);
    int c = 0;
    while (served_q.size() < n && c < max_cyc) begin
      cycle();
      c++;
    end
    check_eq("served_count", served_q.size(), n);
  endtask

  task automatic clear_model();
    pend = '0; waitres = '0; res_rdy_en = '1;
    for (int i = 0; i < NREQ; i++) begin ra[i] = '0; rb[i] = '0; end
    g_busy = 1'b0; g_out = 1'b0; g_cnt = 0; g_res_v = '0;
    m_inflight = 1'b0; m_id = 0; m_ptr = 0; m_last = 0; m_age = 0;
    hs_ops = 1'b0; hs_gacc = 1'b0; hs_gret = 1'b0; hs_res = 1'b0;
    served_q.delete();
    res_q.delete();
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_ops_rdy", req_ops_rdy, 0);
    check_eq("rst_res_val", req_res_val, 0);
    check_eq("rst_gcd_ops_val", gcd_ops_val, 0);
    check_eq("rst_gcd_res_rdy", gcd_res_rdy, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_grant_id", grant_id, 0);
    check_eq("rst_req_res", req_res, 0);
    check_eq("rst_gcd_A", gcd_A, 0);
    check_eq("rst_gcd_B", gcd_B, 0);
  endtask

  // Asserted away from the clock edge so the asynchronous path is what clears the outputs.
  task automatic assert_reset();
    #2;
    rst_b = 1'b0;
    #1;
    check_reset_outputs();
    clear_model();
    drive();
  endtask

  task automatic new_req(input int i, input int a, input int b);
    pend[i] = 1'b1;
    ra[i]   = WL'(a);
    rb[i]   = WL'(b);
  endtask

  task automatic expect_order(input string tag, input int ids[], input int vals[]);
    for (int k = 0; k < ids.size(); k++) begin
      if (k < served_q.size()) begin
        check_eq({tag, "_id"}, served_q[k], ids[k]);
        check_eq({tag, "_res"}, res_q[k], vals[k]);
      end
    end
    served_q.delete();
    res_q.delete();
  endtask

  initial begin
    int c;
    g_rdy_en = 1'b1; g_lat_max = 4; n_acc = 0; seen_res = 1'b0;
    clear_model();
    rst_b = 1'b1;
    drive();
    #1 rst_b = 1'b0;
    #1 check_reset_outputs();
    run(2);
    #2 rst_b = 1'b1;

    // single request
    new_req(0, 6, 4);
    wait_served(1, 60);
    expect_order("single", '{0}, '{2});

    // all four requesting at reset release
    assert_reset();
    new_req(0, 6, 8); new_req(1, 12, 18); new_req(2, 7, 5); new_req(3, 9, 3);
    run(2);
    #2 rst_b = 1'b1;
    wait_served(4, 200);
    expect_order("simul", '{0, 1, 2, 3}, '{2, 6, 1, 3});

    // pointer wrap: after serving 2, requester 3 outranks 0
    new_req(2, 8, 12);
    wait_served(1, 60);
    expect_order("rot_a", '{2}, '{4});
    new_req(0, 15, 10); new_req(3, 21, 14);
    wait_served(2, 120);
    expect_order("rot_b", '{3, 0}, '{7, 5});

    // backpressure on both the GCD operand and the requester result side
    g_rdy_en = 1'b0;
    new_req(1, 9, 6);
    c = 0;
    while (!m_inflight && c < 20) begin cycle(); c++; end
    check_eq("bp_accepted", m_inflight, 1);
    new_req(0, 0, 5);
    run(5);
    g_rdy_en = 1'b1;
    res_rdy_en[1] = 1'b0;
    seen_res = 1'b0; c = 0;
    while (!seen_res && c < 40) begin cycle(); c++; end
    check_eq("bp_res_seen", seen_res, 1);
    run(4);
    res_rdy_en[1] = 1'b1;
    wait_served(2, 120);
    expect_order("bp", '{1, 0}, '{3, 5});

    // reset while waiting on the GCD unit
    g_lat_max = 20;
    new_req(2, 6, 4);
    c = 0;
    while (!(g_busy && !g_out) && c < 40) begin cycle(); c++; end
    check_eq("midrst_in_wait", g_busy, 1);
    assert_reset();
    g_lat_max = 4;
    run(2);
    #2 rst_b = 1'b1;
    new_req(1, 10, 4);
    wait_served(1, 60);
    expect_order("midrst", '{1}, '{2});

    // idle
    run(20);
    check_eq("idle_busy", busy, 0);

    // randomized traffic, then drain
    n_acc = 0;
    g_lat_max = 8;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && !waitres[i] && $urandom_range(3, 0) == 0)
          new_req(i, ($urandom_range(7, 0) == 0) ? 0 : $urandom_range(255, 0),
                     ($urandom_range(7, 0) == 0) ? 0 : $urandom_range(255, 0));
        res_rdy_en[i] = ($urandom_range(3, 0) != 0);
      end
      g_rdy_en = ($urandom_range(3, 0) != 0);
      cycle();
    end
    res_rdy_en = '1;
    g_rdy_en   = 1'b1;
    c = 0;
    while ((m_inflight || pend != '0) && c < 500) begin cycle(); c++; end
    check_eq("rand_drained", m_inflight, 0);
    check_eq("rand_served_all", served_q.size(), n_acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
